parity_scan_ctrl: RTL and testbench

Sequencing controller for the address-counter / fetch-ROM / parity-check datapath. On a start request it walks the fetch memory address range one word per clock and checks each data byte against its stored parity bit. It counts mismatches, records the first failing address, and reports completion with a done pulse. It replaces the free-running counter as the address source, so a system can run a bounded, repeatable integrity scan on demand.

---
 rtl/parity_scan_ctrl.sv | 97 +++++++++
 tb/tb_parity_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_scan_ctrl.sv
// Bounded parity-integrity scan over the fetch memory: walks 0..LAST_ADDR, counts mismatches, reports done.
// Build option: PARITY_SCAN_STOP_ON_ERR_EN ends the scan at the first mismatching word.
module parity_scan_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_parity,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_cnt,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // SCAN  | one word checked per clock, addr advancing
    // DONE  | one-cycle completion pulse, then back to IDLE

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t state;
    logic   mismatch;
    logic   scan_end;

    assign mismatch = ((^s_data) != s_parity);

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
    assign scan_end = (addr == LAST) || mismatch;
`else
    assign scan_end = (addr == LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state          <= SCAN;
                        busy           <= 1'b1;
                        addr           <= '0;
                        err_cnt        <= '0;
                        err_flag       <= 1'b0;
                        first_err_addr <= '0;
                    end
                end
                SCAN: begin
                    if (mismatch) begin
                        err_cnt  <= err_cnt + 1'b1;
                        err_flag <= 1'b1;
                        // err_flag is cleared at start, so low here means no earlier mismatch
                        if (!err_flag)
                            first_err_addr <= addr;
                    end
                    if (scan_end) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Scoreboard bench for parity_scan_ctrl: a full-range instance plus a LAST_ADDR=0 instance.
module tb_parity_scan_ctrl;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int LAST = 15;

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start0 = 1'b0;
    logic [AW-1:0] addr, addr0, first_err_addr, first_err_addr0;
    logic [DW-1:0] s_data, s_data0;
    logic          s_parity, s_parity0;
    logic          busy, busy0, done, done0, err_flag, err_flag0;
    logic [AW:0]   err_cnt, err_cnt0;

    logic [DW-1:0] mem_d  [16];
    logic          mem_p  [16];
    logic [DW-1:0] mem0_d [16];
    logic          mem0_p [16];

    assign s_data    = mem_d[addr];
    assign s_parity  = mem_p[addr];
    assign s_data0   = mem0_d[addr0];
    assign s_parity0 = mem0_p[addr0];

    parity_scan_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST)) u_dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .s_data(s_data), .s_parity(s_parity),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_flag(err_flag), .first_err_addr(first_err_addr)
    );

    parity_scan_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .addr(addr0), .s_data(s_data0), .s_parity(s_parity0),
        .busy(busy0), .done(done0), .err_cnt(err_cnt0), .err_flag(err_flag0), .first_err_addr(first_err_addr0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int cnt;
        int first;
        int fin;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the memory image word by word and apply the parity rule directly.
    function automatic exp_t model(input int last, input bit sel);
        exp_t e;
        bit   found = 1'b0;
        e.cnt = 0; e.first = 0; e.fin = last; e.start_cyc = 0;
        for (int a = 0; a <= last; a++) begin
            logic [DW-1:0] d;
            logic          p;
            d = sel ? mem0_d[a] : mem_d[a];
            p = sel ? mem0_p[a] : mem_p[a];
            if ((^d) != p) begin
                if (!found) e.first = a;
                found = 1'b1;
                e.cnt++;
                if (STOP) begin
                    e.fin = a;
                    break;
                end
            end
        end
        e.lat = e.fin + 1;
        return e;
    endfunction

    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            chk("done_single_cycle", int'(done_d), 0);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("err_cnt", int'(err_cnt), e.cnt);
                chk("err_flag", int'(err_flag), int'(e.cnt != 0));
                chk("first_err_addr", int'(first_err_addr), e.first);
                chk("final_addr", int'(addr), e.fin);
                chk("done_latency", cyc - e.start_cyc, e.lat);
                chk("busy_at_done", int'(busy), 0);
            end
        end
        done_d = done;
    end

    logic done0_d = 1'b0;
    always @(negedge clk) begin
        if (done0) begin
            chk("done0_single_cycle", int'(done0_d), 0);
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done0 actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("err_cnt0", int'(err_cnt0), e.cnt);
                chk("err_flag0", int'(err_flag0), int'(e.cnt != 0));
                chk("first_err_addr0", int'(first_err_addr0), e.first);
                chk("final_addr0", int'(addr0), e.fin);
                chk("done0_latency", cyc - e.start_cyc, e.lat);
            end
        end
        done0_d = done0;
    end

    task automatic wait_drain(input bit sel);
        int n = 0;
        while (((sel ? q0.size() : q.size()) != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? q0.size() : q.size()) != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout actual=no_done expected=done (sel=%0d)", sel);
            if (sel) q0.delete(); else q.delete();
        end
        @(negedge clk);
    endtask

    task automatic scan();
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = model(LAST, 1'b0);
        e.start_cyc = cyc;
        q.push_back(e);
        chk("busy_after_start", int'(busy), 1);
        wait_drain(1'b0);
    endtask

    task automatic fill_good();
        for (int a = 0; a < 16; a++) begin
            mem_d[a] = DW'($urandom);
            mem_p[a] = ^mem_d[a];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=hung expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        fill_good();
        for (int a = 0; a < 16; a++) begin
            mem0_d[a] = '0;
            mem0_p[a] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_err_flag", int'(err_flag), 0);
        chk("rst_first_err_addr", int'(first_err_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // clean memory
        fill_good();
        scan();

        // corrupt words 5 and 9
        mem_p[5] = ~mem_p[5];
        mem_p[9] = ~mem_p[9];
        scan();

        // results must hold in IDLE
        repeat (3) @(negedge clk);
        chk("hold_err_cnt", int'(err_cnt), model(LAST, 1'b0).cnt);
        chk("hold_first_err", int'(first_err_addr), model(LAST, 1'b0).first);

        // randomized memory images
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) begin
                mem_d[a] = DW'($urandom);
                mem_p[a] = (^mem_d[a]) ^ ($urandom_range(0, 3) == 0);
            end
            scan();
        end

        // start held high across two scans
        begin
            exp_t e1, e2;
            int   n = 0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            e1 = model(LAST, 1'b0);
            e1.start_cyc = cyc;
            q.push_back(e1);
            chk("held_busy_first", int'(busy), 1);
            e2 = e1;
            e2.start_cyc = e1.start_cyc + e1.lat + 2;
            q.push_back(e2);
            while (cyc < e2.start_cyc && n < 100) begin
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            chk("held_busy_second", int'(busy), 1);
            wait_drain(1'b0);
        end

        // reset mid-scan at addr 7
        fill_good();
        if (!STOP) mem_p[3] = ~mem_p[3];
        mem_p[9] = ~mem_p[9];
        begin
            int n = 0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (addr != AW'(7) && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reached_addr7", int'(addr), 7);
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_addr", int'(addr), 0);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_err_cnt", int'(err_cnt), 0);
            chk("midrst_done", int'(done), 0);
            rst = 1'b0;
            repeat (25) @(negedge clk);
        end
        scan();

        // LAST_ADDR = 0 instance with corrupt word 0
        mem0_d[0] = DW'($urandom);
        mem0_p[0] = ~(^mem0_d[0]);
        begin
            exp_t e;
            @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            e = model(0, 1'b1);
            e.start_cyc = cyc;
            q0.push_back(e);
            chk("busy0_after_start", int'(busy0), 1);
            wait_drain(1'b1);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
